// File: rtl/id_issue_ctrl_pkg.sv
// Shared types and widths for the ID-stage issue controller: FSM state
// encodings, ID bus widths and GPR count/index width.
package id_issue_ctrl_pkg;
  localparam int XLEN        = 32;
  localparam int GPR_NUM     = 32;
  localparam int GPR_IDX_W   = 5;
  localparam int SB_CNT_W    = 2;
  localparam int STALL_CNT_W = 16;

  // EX, MEM and WB can each hold one writer of the same register
  localparam logic [SB_CNT_W-1:0] SB_CNT_MAX = 2'd3;

  typedef enum logic [1:0] {
    ID_EMPTY = 2'b00,
    ID_HOLD  = 2'b01,
    ID_STALL = 2'b10
  } id_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } id_bus_t;
endpackage

// File: rtl/id_scoreboard.sv
// Per-GPR pending-writer counters with clear/inc/dec and two busy lookups.
module id_scoreboard
  import id_issue_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 inc_i,
  input  logic [GPR_IDX_W-1:0] inc_rd_i,
  input  logic                 dec_i,
  input  logic [GPR_IDX_W-1:0] dec_rd_i,
  input  logic [GPR_IDX_W-1:0] rj_i,
  input  logic [GPR_IDX_W-1:0] rk_i,
  output logic                 rj_busy_o,
  output logic                 rk_busy_o
);

  logic [GPR_NUM-1:0][SB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else begin
      // r0 is hardwired, its counter stays zero
      for (int r = 1; r < GPR_NUM; r++) begin
        if (inc_i && inc_rd_i == GPR_IDX_W'(r) && !(dec_i && dec_rd_i == GPR_IDX_W'(r)))
          cnt_d[r] = cnt_q[r] + 1'b1;
        else if (dec_i && dec_rd_i == GPR_IDX_W'(r) && !(inc_i && inc_rd_i == GPR_IDX_W'(r)))
          cnt_d[r] = cnt_q[r] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign rj_busy_o = (rj_i != '0) && (cnt_q[rj_i] != '0);
  assign rk_busy_o = (rk_i != '0) && (cnt_q[rk_i] != '0);

  a_sb_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    (inc_i && !clr_i && inc_rd_i != '0 && !(dec_i && dec_rd_i == inc_rd_i))
      |-> cnt_q[inc_rd_i] != SB_CNT_MAX);

  a_sb_underflow: assert property (@(posedge clk) disable iff (!rst_n)
    (dec_i && !clr_i && dec_rd_i != '0 && !(inc_i && inc_rd_i == dec_rd_i))
      |-> cnt_q[dec_rd_i] != '0);

endmodule

// File: rtl/id_issue_ctrl.sv
// Decode-stage issue controller: holds the IF instruction, checks RAW hazards
// against in-flight writers and issues to EX. ID_FORWARD_EN selects load-use-only stalls.
module id_issue_ctrl
  import id_issue_ctrl_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   if_valid_i,
  input  logic [XLEN-1:0]        if_pc_i,
  input  logic [XLEN-1:0]        if_inst_i,
  output logic                   id_allowin_o,
  output logic [XLEN-1:0]        dec_inst_o,
  input  logic [GPR_IDX_W-1:0]   dec_rj_i,
  input  logic [GPR_IDX_W-1:0]   dec_rk_i,
  input  logic [GPR_IDX_W-1:0]   dec_rd_i,
  input  logic                   dec_rj_use_i,
  input  logic                   dec_rk_use_i,
  input  logic                   dec_rf_we_i,
  input  logic                   ex_allowin_i,
  output logic                   id_to_ex_valid_o,
  output logic [XLEN-1:0]        id_pc_o,
  output logic [XLEN-1:0]        id_inst_o,
  input  logic                   ex_load_valid_i,
  input  logic [GPR_IDX_W-1:0]   ex_load_rd_i,
  input  logic                   wb_retire_i,
  input  logic                   wb_rf_we_i,
  input  logic [GPR_IDX_W-1:0]   wb_rd_i,
  input  logic                   br_taken_i,
  input  logic                   flush_i,
  output logic [STALL_CNT_W-1:0] stall_cnt_o
);

  id_state_e              state_q, state_d;
  id_bus_t                bus_q, bus_d;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic valid, hazard, issue, allowin, load;
  logic rj_busy, rk_busy, sb_rj_busy, sb_rk_busy;
  logic sb_inc, sb_dec;

  assign valid   = (state_q != ID_EMPTY);
  assign hazard  = valid && ((dec_rj_use_i && rj_busy) || (dec_rk_use_i && rk_busy));
  assign issue   = valid && !hazard && ex_allowin_i && !br_taken_i && !flush_i;
  assign allowin = !valid || issue || br_taken_i || flush_i;
  assign load    = if_valid_i && allowin && !flush_i && !br_taken_i;

  assign sb_inc = issue && dec_rf_we_i && (dec_rd_i != '0);
  assign sb_dec = wb_retire_i && wb_rf_we_i && (wb_rd_i != '0);

  id_scoreboard u_sb (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (flush_i),
    .inc_i     (sb_inc),
    .inc_rd_i  (dec_rd_i),
    .dec_i     (sb_dec),
    .dec_rd_i  (wb_rd_i),
    .rj_i      (dec_rj_i),
    .rk_i      (dec_rk_i),
    .rj_busy_o (sb_rj_busy),
    .rk_busy_o (sb_rk_busy)
  );

`ifdef ID_FORWARD_EN
  // Everything but a load in EX is forwarded; counters only feed the assertions
  logic unused_sb_busy;
  assign unused_sb_busy = sb_rj_busy ^ sb_rk_busy;
  assign rj_busy = ex_load_valid_i && (ex_load_rd_i == dec_rj_i) && (dec_rj_i != '0);
  assign rk_busy = ex_load_valid_i && (ex_load_rd_i == dec_rk_i) && (dec_rk_i != '0);
`else
  logic unused_ex_load;
  assign unused_ex_load = ex_load_valid_i ^ (^ex_load_rd_i);
  assign rj_busy = sb_rj_busy;
  assign rk_busy = sb_rk_busy;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ID_EMPTY: if (load) state_d = ID_HOLD;
      ID_HOLD, ID_STALL: begin
        if (load)                   state_d = ID_HOLD;
        else if (issue || br_taken_i) state_d = ID_EMPTY;
        else                        state_d = hazard ? ID_STALL : ID_HOLD;
      end
      default: state_d = ID_EMPTY;
    endcase
    if (flush_i) state_d = ID_EMPTY;
  end

  always_comb begin
    bus_d = bus_q;
    if (load) begin
      bus_d.pc   = if_pc_i;
      bus_d.inst = if_inst_i;
    end
  end

  // A flushed cycle is not a hazard stall even if the dependency was live
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush_i && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ID_EMPTY;
      bus_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign id_allowin_o     = allowin;
  assign id_to_ex_valid_o = issue;
  assign dec_inst_o       = bus_q.inst;
  assign id_pc_o          = bus_q.pc;
  assign id_inst_o        = bus_q.inst;
  assign stall_cnt_o      = stall_cnt_q;

endmodule

// File: tb/tb_id_issue_ctrl.sv
// Bench for id_issue_ctrl: queue-based pipeline model, directed scenarios, random stream.
module tb_id_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid_i;
  logic [31:0] if_pc_i, if_inst_i;
  logic        id_allowin_o;
  logic [31:0] dec_inst_o;
  logic [4:0]  dec_rj_i, dec_rk_i, dec_rd_i;
  logic        dec_rj_use_i, dec_rk_use_i, dec_rf_we_i;
  logic        ex_allowin_i;
  logic        id_to_ex_valid_o;
  logic [31:0] id_pc_o, id_inst_o;
  logic        ex_load_valid_i;
  logic [4:0]  ex_load_rd_i;
  logic        wb_retire_i, wb_rf_we_i;
  logic [4:0]  wb_rd_i;
  logic        br_taken_i, flush_i;
  logic [15:0] stall_cnt_o;

  always #5 clk = ~clk;

  id_issue_ctrl dut (
    .clk(clk), .rst_n(rst_n), .if_valid_i(if_valid_i), .if_pc_i(if_pc_i), .if_inst_i(if_inst_i),
    .id_allowin_o(id_allowin_o), .dec_inst_o(dec_inst_o), .dec_rj_i(dec_rj_i), .dec_rk_i(dec_rk_i),
    .dec_rd_i(dec_rd_i), .dec_rj_use_i(dec_rj_use_i), .dec_rk_use_i(dec_rk_use_i),
    .dec_rf_we_i(dec_rf_we_i), .ex_allowin_i(ex_allowin_i), .id_to_ex_valid_o(id_to_ex_valid_o),
    .id_pc_o(id_pc_o), .id_inst_o(id_inst_o), .ex_load_valid_i(ex_load_valid_i),
    .ex_load_rd_i(ex_load_rd_i), .wb_retire_i(wb_retire_i), .wb_rf_we_i(wb_rf_we_i),
    .wb_rd_i(wb_rd_i), .br_taken_i(br_taken_i), .flush_i(flush_i), .stall_cnt_o(stall_cnt_o)
  );

  // Stand-in decoder: rd/rj/rk at LoongArch 3R positions, use/we flags in bits 15..17
  assign dec_rd_i     = dec_inst_o[4:0];
  assign dec_rj_i     = dec_inst_o[9:5];
  assign dec_rk_i     = dec_inst_o[14:10];
  assign dec_rj_use_i = dec_inst_o[15];
  assign dec_rk_use_i = dec_inst_o[16];
  assign dec_rf_we_i  = dec_inst_o[17];

  function automatic logic [31:0] mk(input logic [4:0] rd, rj, rk, input logic rju, rku, we);
    return {14'h0040, we, rku, rju, rk, rj, rd};
  endfunction

  typedef struct {logic we; logic [4:0] rd; int c;} pe_t;
  pe_t pipe[$];              // issued, not yet retired, oldest first

  int          n_chk = 0, n_pass = 0, cyc = 0;
  bit          rnd_mode = 0, hold_retire = 0;
  logic        m_valid;
  logic [31:0] m_pc, m_inst;
  int          m_stall;
  logic        s_issue, s_allow;
  logic [15:0] s_stall;
  int          base, n_iss;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic logic m_busy(input logic [4:0] r);
`ifdef ID_FORWARD_EN
    return ex_load_valid_i && ex_load_rd_i == r && r != 5'd0;
`else
    if (r == 5'd0) return 1'b0;
    foreach (pipe[i]) if (pipe[i].we && pipe[i].rd == r) return 1'b1;
    return 1'b0;
`endif
  endfunction

  task automatic m_reset();
    m_valid = 1'b0; m_pc = '0; m_inst = '0; m_stall = 0;
    pipe.delete();
  endtask

  task automatic cyc_step(input logic ifv, input logic [31:0] pc, input logic [31:0] inst,
                          input logic exa, input logic br, input logic fl);
    logic ret, haz, iss, alw, ld;
    @(negedge clk);
    if_valid_i = ifv; if_pc_i = pc; if_inst_i = inst; br_taken_i = br; flush_i = fl;
    ret = pipe.size() > 0 && (cyc - pipe[0].c) >= 3 && !hold_retire &&
          (!rnd_mode || $urandom_range(0, 3) != 0);
    wb_retire_i = ret;
    if (ret) begin wb_rf_we_i = pipe[0].we; wb_rd_i = pipe[0].rd; end
    else begin wb_rf_we_i = 1'($urandom_range(0, 1)); wb_rd_i = 5'($urandom_range(0, 31)); end
    ex_allowin_i = exa && ((pipe.size() - int'(ret)) < 3);
    #1;
    haz = m_valid && ((m_inst[15] && m_busy(m_inst[9:5])) || (m_inst[16] && m_busy(m_inst[14:10])));
    iss = m_valid && !haz && ex_allowin_i && !br && !fl;
    alw = !m_valid || iss || br || fl;
    ld  = ifv && alw && !fl && !br;
    chk("allowin", 32'(id_allowin_o), 32'(alw));
    chk("issue", 32'(id_to_ex_valid_o), 32'(iss));
    chk("id_pc", id_pc_o, m_pc);
    chk("id_inst", id_inst_o, m_inst);
    chk("dec_inst", dec_inst_o, m_inst);
    chk("stall_cnt", 32'(stall_cnt_o), 32'(m_stall));
    s_issue = id_to_ex_valid_o; s_allow = id_allowin_o; s_stall = stall_cnt_o;
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
      pipe.delete();
    end else begin
      if (ret) void'(pipe.pop_front());
      if (iss) pipe.push_back('{we: m_inst[17], rd: m_inst[4:0], c: cyc});
      if (ld) begin m_valid = 1'b1; m_pc = pc; m_inst = inst; end
      else if (iss || br) m_valid = 1'b0;
      if (haz && m_stall < 65535) m_stall++;
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_allowin"}, 32'(id_allowin_o), 32'd1);
    chk({tag, "_issue"}, 32'(id_to_ex_valid_o), 32'd0);
    chk({tag, "_pc"}, id_pc_o, 32'd0);
    chk({tag, "_inst"}, id_inst_o, 32'd0);
    chk({tag, "_dec_inst"}, dec_inst_o, 32'd0);
    chk({tag, "_stall"}, 32'(stall_cnt_o), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid_i = 0; if_pc_i = 0; if_inst_i = 0; ex_allowin_i = 0; ex_load_valid_i = 0;
    ex_load_rd_i = 0; wb_retire_i = 0; wb_rf_we_i = 0; wb_rd_i = 0; br_taken_i = 0; flush_i = 0;
    m_reset();
    repeat (3) @(posedge clk);
    #1 chk_reset_vals("reset");
    @(negedge clk) rst_n = 1'b1;

`ifndef ID_FORWARD_EN
    // reset while a dependent instruction sits in STALL with 5 counted cycles
    cyc_step(1'b1, 32'h1c000000, mk(14, 20, 21, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b1, 32'h1c000004, mk(15, 14, 6, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    chk("rst_writer_issue", 32'(s_issue), 32'd1);
    hold_retire = 1;
    idle(5);
    @(negedge clk); #1;
    chk("rst_pre_stall", 32'(stall_cnt_o), 32'd5);
    chk("rst_pre_issue", 32'(id_to_ex_valid_o), 32'd0);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("midreset");
    m_reset(); hold_retire = 0;
    @(negedge clk) rst_n = 1'b1;
`endif

    // independent add.w stream: one issue per cycle, no stalls
    base = m_stall; n_iss = 0;
    for (int i = 1; i <= 4; i++) begin
      cyc_step(1'b1, 32'h1c000100 + 32'(4 * i), mk(5'(i), 20, 21, 1, 1, 1), 1'b1, 1'b0, 1'b0);
      n_iss += int'(s_issue);
    end
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    n_iss += int'(s_issue);
    chk("stream_issues", 32'(n_iss), 32'd4);
    chk("stream_stall", 32'(s_stall), 32'(base));
    idle(4);

`ifndef ID_FORWARD_EN
    // add.w r4 then add.w r5,r4,r6: three stall cycles until r4 retires
    cyc_step(1'b1, 32'h1c000200, mk(4, 20, 21, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b1, 32'h1c000204, mk(5, 4, 6, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    base = int'(s_stall);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("raw_stall1", 32'(s_issue), 32'd0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("raw_stall3", 32'(s_issue), 32'd0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("raw_issue", 32'(s_issue), 32'd1);
    chk("raw_stall_delta", 32'(int'(s_stall) - base), 32'd3);
    idle(4);

    // branch drops a stalled instruction; r7 stays busy afterwards
    cyc_step(1'b1, 32'h1c000300, mk(7, 20, 21, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b1, 32'h1c000304, mk(8, 7, 6, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 1'b0);
    chk("br_allowin", 32'(s_allow), 32'd1);
    chk("br_no_issue", 32'(s_issue), 32'd0);
    cyc_step(1'b1, 32'h1c000400, mk(9, 7, 20, 1, 0, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("br_sb_kept", 32'(s_issue), 32'd0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("br_after_retire", 32'(s_issue), 32'd1);
    idle(4);
`endif

    // flush coinciding with a retire and an issuable instruction
    cyc_step(1'b1, 32'h1c000500, mk(10, 20, 21, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b1, 32'h1c000504, mk(13, 20, 21, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b1, 32'h1c000508, mk(11, 20, 21, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1);
    chk("flush_retire_seen", 32'(wb_retire_i), 32'd1);
    chk("flush_no_issue", 32'(s_issue), 32'd0);
    base = int'(stall_cnt_o);
    cyc_step(1'b1, 32'h1c000600, mk(12, 13, 10, 1, 1, 1), 1'b1, 1'b0, 1'b0);
    chk("flush_empty_allowin", 32'(s_allow), 32'd1);
    chk("flush_empty_issue", 32'(s_issue), 32'd0);
    cyc_step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
    chk("flush_sb_clear", 32'(s_issue), 32'd1);
    chk("flush_no_stall", 32'(s_stall), 32'(base));
    idle(4);

    // random stream against the model
    rnd_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      ex_load_valid_i = 1'($urandom_range(0, 1));
      ex_load_rd_i    = 5'($urandom_range(0, 7));
      cyc_step($urandom_range(0, 9) < 7, $urandom,
               mk(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1))),
               $urandom_range(0, 7) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
